// File: rtl/mp64_mem_arbiter_pkg.sv
// ============================================================================
// mp64_mem_arbiter_pkg : shared constants and state encoding for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mp64_mem_arbiter_pkg;

    localparam int ARB_DATA_W = 64;

    localparam logic [1:0] ARB_OWNER_NONE = 2'd0;
    localparam logic [1:0] ARB_OWNER_TILE = 2'd1;
    localparam logic [1:0] ARB_OWNER_CPU  = 2'd2;

    localparam logic [ARB_DATA_W-1:0] ARB_ERR_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ARB_ST_IDLE = 2'd0,
        ARB_ST_BUSY = 2'd1,
        ARB_ST_DONE = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mp64_mem_arbiter_if.sv
// ============================================================================
// mp64_mem_arbiter_if : one requester channel (request fields + response)
// Rev 1.0
// ============================================================================
`default_nettype none

interface mp64_mem_arbiter_if;
    import mp64_mem_arbiter_pkg::*;

    logic                  valid;
    logic [ARB_DATA_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic                  wen;
    logic [1:0]            size;
    logic [ARB_DATA_W-1:0] rdata;
    logic                  ready;
    logic                  err;

    modport master (
        output valid, addr, wdata, wen, size,
        input  rdata, ready, err
    );

    modport slave (
        input  valid, addr, wdata, wen, size,
        output rdata, ready, err
    );

endinterface

`default_nettype wire

// File: rtl/mp64_arb_timeout.sv
// ============================================================================
// mp64_arb_timeout : ack-timeout counter with clear, enable and terminal flag
// Rev 1.0
// ============================================================================
`default_nettype none

module mp64_arb_timeout #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    input  wire logic en,
    output logic      tc
);

    generate
        if (ACK_TIMEOUT == 0) begin : g_disabled
            assign tc = 1'b0;
        end else begin : g_enabled
            localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
            localparam logic [CNT_W-1:0] c_term = CNT_W'(ACK_TIMEOUT - 1);

            logic [CNT_W-1:0] r_count;

            // Holds at the terminal value so it can never wrap back to zero.
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_count <= '0;
                end else if (en && (r_count != c_term)) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            assign tc = (r_count == c_term);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mp64_mem_arbiter.sv
// ============================================================================
// mp64_mem_arbiter : tile-priority arbiter for the shared memory port with
//                    CPU starvation guard and ack-timeout abort
// Rev 1.0
// ============================================================================
`default_nettype none

module mp64_mem_arbiter
    import mp64_mem_arbiter_pkg::*;
#(
    parameter int CPU_STARVE_MAX = 4,
    parameter int ACK_TIMEOUT    = 1024
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    mp64_mem_arbiter_if.slave          tile,
    mp64_mem_arbiter_if.slave          cpu,
    output logic                       mem_req,
    output logic [ARB_DATA_W-1:0]      mem_addr,
    output logic [ARB_DATA_W-1:0]      mem_wdata,
    output logic                       mem_wen,
    output logic [1:0]                 mem_size,
    input  wire logic [ARB_DATA_W-1:0] mem_rdata,
    input  wire logic                  mem_ack,
    output logic [1:0]                 owner
);

    localparam logic [7:0] c_starve_max = 8'(CPU_STARVE_MAX);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic [7:0] r_starve;
    logic       w_grant_tile;
    logic       w_grant_cpu;
    logic       w_complete;
    logic       w_abort;
    logic       w_cpu_wins;
    logic       w_tc;

    mp64_arb_timeout #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (w_grant_tile | w_grant_cpu),
        .en  ((r_state == ARB_ST_BUSY) && !mem_ack),
        .tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_tile = 1'b0;
        w_grant_cpu  = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_cpu_wins   = cpu.valid && (!tile.valid || (r_starve == c_starve_max));
        case (r_state)
            ARB_ST_IDLE: begin
                if (tile.valid || cpu.valid) begin
                    w_state_next = ARB_ST_BUSY;
                    w_grant_cpu  = w_cpu_wins;
                    w_grant_tile = !w_cpu_wins;
                end
            end
            ARB_ST_BUSY: begin
                // An ack on the final timeout cycle still completes normally.
                if (mem_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = ARB_ST_DONE;
                end else if (w_tc) begin
                    w_abort      = 1'b1;
                    w_state_next = ARB_ST_DONE;
                end
            end
            ARB_ST_DONE: w_state_next = ARB_ST_IDLE;
            default:     w_state_next = ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wen    <= 1'b0;
            mem_size   <= 2'd0;
            owner      <= ARB_OWNER_NONE;
            r_starve   <= 8'd0;
            tile.rdata <= '0;
            tile.ready <= 1'b0;
            tile.err   <= 1'b0;
            cpu.rdata  <= '0;
            cpu.ready  <= 1'b0;
            cpu.err    <= 1'b0;
        end else begin
            tile.ready <= 1'b0;
            tile.err   <= 1'b0;
            cpu.ready  <= 1'b0;
            cpu.err    <= 1'b0;

            if (w_grant_tile) begin
                mem_req   <= 1'b1;
                mem_addr  <= tile.addr;
                mem_wdata <= tile.wdata;
                mem_wen   <= tile.wen;
                mem_size  <= tile.size;
                owner     <= ARB_OWNER_TILE;
                if (!cpu.valid) begin
                    r_starve <= 8'd0;
                end else if (r_starve != c_starve_max) begin
                    r_starve <= r_starve + 8'd1;
                end
            end

            if (w_grant_cpu) begin
                mem_req   <= 1'b1;
                mem_addr  <= cpu.addr;
                mem_wdata <= cpu.wdata;
                mem_wen   <= cpu.wen;
                mem_size  <= cpu.size;
                owner     <= ARB_OWNER_CPU;
                r_starve  <= 8'd0;
            end

            if (w_complete || w_abort) begin
                mem_req <= 1'b0;
                if (owner == ARB_OWNER_TILE) begin
                    tile.rdata <= w_abort ? ARB_ERR_RDATA : mem_rdata;
                    tile.ready <= 1'b1;
                    tile.err   <= w_abort;
                end else begin
                    cpu.rdata <= w_abort ? ARB_ERR_RDATA : mem_rdata;
                    cpu.ready <= 1'b1;
                    cpu.err   <= w_abort;
                end
            end

            if (r_state == ARB_ST_DONE) begin
                owner <= ARB_OWNER_NONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mp64_mem_arbiter.sv
// ============================================================================
// tb_mp64_mem_arbiter : directed self-checking bench for mp64_mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mp64_mem_arbiter;
    import mp64_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wen;
    logic [1:0]  mem_size;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_pass   = 0;
    int n_tile;
    int cnt;
    int exp_owner [6] = '{1, 1, 1, 1, 2, 1};

    mp64_mem_arbiter_if tile_if ();
    mp64_mem_arbiter_if cpu_if ();

    always #5 clk = ~clk;

    mp64_mem_arbiter #(
        .CPU_STARVE_MAX (4),
        .ACK_TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tile      (tile_if),
        .cpu       (cpu_if),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_size  (mem_size),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .owner     (owner)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        tile_if.valid = 1'b0;
        tile_if.addr  = '0;
        tile_if.wdata = '0;
        tile_if.wen   = 1'b0;
        tile_if.size  = 2'd0;
        cpu_if.valid  = 1'b0;
        cpu_if.addr   = '0;
        cpu_if.wdata  = '0;
        cpu_if.wen    = 1'b0;
        cpu_if.size   = 2'd0;
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_owner", owner, 0);
        check("rst_tile_ready", tile_if.ready, 0);
        check("rst_cpu_ready", cpu_if.ready, 0);
        check("rst_cpu_err", cpu_if.err, 0);
        check("rst_cpu_rdata", cpu_if.rdata, 0);
        check("rst_tile_rdata", tile_if.rdata, 0);
        rst = 1'b0;
        tick();

        // CPU alone: read 0x1000, ack in the third BUSY cycle
        cpu_if.valid = 1'b1;
        cpu_if.addr  = 64'h0000_1000;
        cpu_if.size  = 2'd3;
        tick();
        check("cpu_req_c1", mem_req, 1);
        check("cpu_owner", owner, 2);
        check("cpu_mem_addr", mem_addr, 64'h1000);
        check("cpu_mem_wen", mem_wen, 0);
        check("cpu_mem_size", mem_size, 3);
        tick();
        check("cpu_req_c2", mem_req, 1);
        tick();
        check("cpu_req_c3", mem_req, 1);
        check("cpu_no_early_ready", cpu_if.ready, 0);
        mem_ack   = 1'b1;
        mem_rdata = 64'hDEAD_BEEF;
        tick();
        mem_ack      = 1'b0;
        cpu_if.valid = 1'b0;
        check("cpu_req_dropped", mem_req, 0);
        check("cpu_ready", cpu_if.ready, 1);
        check("cpu_rdata", cpu_if.rdata, 64'hDEAD_BEEF);
        check("cpu_err", cpu_if.err, 0);
        check("cpu_tile_ready_quiet", tile_if.ready, 0);
        tick();
        check("cpu_ready_pulse_end", cpu_if.ready, 0);
        check("cpu_owner_cleared", owner, 0);

        // Tile write; fields frozen while BUSY
        tile_if.valid = 1'b1;
        tile_if.addr  = 64'h2000;
        tile_if.wdata = 64'h1111_2222_3333_4444;
        tile_if.wen   = 1'b1;
        tile_if.size  = 2'd2;
        tick();
        check("tile_owner", owner, 1);
        check("tile_mem_addr", mem_addr, 64'h2000);
        check("tile_mem_wdata", mem_wdata, 64'h1111_2222_3333_4444);
        check("tile_mem_wen", mem_wen, 1);
        check("tile_mem_size", mem_size, 2);
        tile_if.addr = 64'h3000;
        tile_if.wen  = 1'b0;
        tick();
        check("frozen_addr_c2", mem_addr, 64'h2000);
        check("frozen_wen_c2", mem_wen, 1);
        mem_ack   = 1'b1;
        mem_rdata = 64'h0;
        tick();
        mem_ack       = 1'b0;
        tile_if.valid = 1'b0;
        check("tile_ready", tile_if.ready, 1);
        check("tile_err", tile_if.err, 0);
        check("tile_cpu_ready_quiet", cpu_if.ready, 0);
        check("cpu_rdata_held", cpu_if.rdata, 64'hDEAD_BEEF);
        tick();

        // Both pending: four tile grants, then the CPU, then tile again
        tile_if.valid = 1'b1;
        tile_if.addr  = 64'h5000;
        cpu_if.valid  = 1'b1;
        cpu_if.addr   = 64'h6000;
        n_tile        = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("arb_owner_%0d", i), owner, 64'(exp_owner[i]));
            mem_ack   = 1'b1;
            mem_rdata = 64'h100 + 64'(i);
            tick();
            mem_ack = 1'b0;
            if (tile_if.ready) n_tile++;
            if (exp_owner[i] == 1) begin
                check($sformatf("arb_tile_ready_%0d", i), tile_if.ready, 1);
                check($sformatf("arb_tile_rdata_%0d", i), tile_if.rdata, 64'h100 + 64'(i));
                check($sformatf("arb_cpu_quiet_%0d", i), cpu_if.ready, 0);
            end else begin
                check("arb_cpu_ready", cpu_if.ready, 1);
                check("arb_cpu_rdata", cpu_if.rdata, 64'h100 + 64'(i));
                check("arb_tile_pulses_before_cpu", 64'(n_tile), 4);
                cpu_if.valid = 1'b0;
            end
            tick();
        end
        tile_if.valid = 1'b0;
        tick();

        // Timeout: no ack ever, ACK_TIMEOUT = 8
        cpu_if.valid = 1'b1;
        cpu_if.addr  = 64'h4000;
        tick();
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 20) begin
            cnt++;
            tick();
        end
        check("to_req_cycles", 64'(cnt), 8);
        check("to_ready", cpu_if.ready, 1);
        check("to_err", cpu_if.err, 1);
        check("to_rdata", cpu_if.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        cpu_if.valid = 1'b0;
        tick();
        check("to_ready_end", cpu_if.ready, 0);
        check("to_err_end", cpu_if.err, 0);
        check("to_owner_end", owner, 0);

        // Normal request after the abort
        cpu_if.valid = 1'b1;
        cpu_if.addr  = 64'h4008;
        tick();
        check("post_to_req", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 64'h1234;
        tick();
        mem_ack      = 1'b0;
        cpu_if.valid = 1'b0;
        check("post_to_ready", cpu_if.ready, 1);
        check("post_to_err", cpu_if.err, 0);
        check("post_to_rdata", cpu_if.rdata, 64'h1234);
        tick();

        // Ack lands on the final timeout cycle
        cpu_if.valid = 1'b1;
        cpu_if.addr  = 64'h4010;
        tick();
        repeat (7) tick();
        check("tc_ack_req_held", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 64'hCAFE;
        tick();
        mem_ack      = 1'b0;
        cpu_if.valid = 1'b0;
        check("tc_ack_ready", cpu_if.ready, 1);
        check("tc_ack_err", cpu_if.err, 0);
        check("tc_ack_rdata", cpu_if.rdata, 64'hCAFE);
        tick();

        // Reset in the middle of a tile transaction
        tile_if.valid = 1'b1;
        tile_if.addr  = 64'h7000;
        tick();
        check("rb_req", mem_req, 1);
        tick();
        rst           = 1'b1;
        tile_if.valid = 1'b0;
        tick();
        check("rb_req_dropped", mem_req, 0);
        check("rb_owner", owner, 0);
        check("rb_tile_ready", tile_if.ready, 0);
        check("rb_tile_rdata", tile_if.rdata, 0);
        rst = 1'b0;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 64'h9999;
        tick();
        mem_ack = 1'b0;
        check("rb_late_ack_tile", tile_if.ready, 0);
        check("rb_late_ack_cpu", cpu_if.ready, 0);
        check("rb_late_ack_req", mem_req, 0);
        tick();
        check("rb_late_ack_tile2", tile_if.ready, 0);
        check("rb_late_ack_rdata", tile_if.rdata, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mp64_mem_arbiter.md
Name: mp64_mem_arbiter

Overview:
- Shares the single memory-subsystem port (BRAM + external forwarding) between two masters: the tile engine and the CPU memory path.
- Grants tile-engine requests with priority, and a starvation guard bounds CPU wait.
- Holds one transaction in flight at a time and snapshots the request fields at grant.
- Aborts a transaction with an error response if the memory side never acks.

Parameters:
- CPU_STARVE_MAX, 4: consecutive tile grants allowed while the CPU is pending; the next arbitration then goes to the CPU. Range 1..255.
- ACK_TIMEOUT, 1024: cycles in BUSY without mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tile_valid  in  1  tile request pending; held until tile_ready
- tile_addr  in  64  byte address
- tile_wdata  in  64  write data
- tile_wen  in  1  1 = write
- tile_size  in  2  access size, same encoding as the memory port
- tile_rdata  out  64  read data, valid with tile_ready
- tile_ready  out  1  single-cycle completion pulse
- tile_err  out  1  timeout abort flag, qualified by tile_ready
- cpu_valid / cpu_addr / cpu_wdata / cpu_wen / cpu_size  in  1/64/64/1/2  CPU request, same rules as the tile port
- cpu_rdata / cpu_ready / cpu_err  out  64/1/1  CPU response, same rules as the tile port
- mem_req  out  1  held high until mem_ack or abort
- mem_addr / mem_wdata / mem_wen / mem_size  out  64/64/1/2  snapshotted fields, stable while mem_req is high
- mem_rdata  in  64  read data, valid with mem_ack
- mem_ack  in  1  completion from the memory subsystem
- owner  out  2  current owner: 0 = none, 1 = tile, 2 = CPU

Behaviour:
- Reset (rst sampled high at posedge):
  - state = IDLE; mem_req, tile_ready, cpu_ready, tile_err, cpu_err = 0; owner = 0.
  - rdata outputs = 0; starve counter = 0; timeout counter = 0.
  - Reset mid-transaction drops mem_req at that edge and issues no ready pulse. A mem_ack for the abandoned transaction arriving after reset is ignored.
- States:
  - IDLE → BUSY when any valid is high, at the same edge as the grant decision.
  - BUSY → DONE on mem_ack, or on timeout.
  - DONE → IDLE unconditionally after one cycle.
- Grant decision (IDLE only):
  - Tile only: tile. CPU only: CPU.
  - Both pending: CPU if starve counter == CPU_STARVE_MAX, else tile.
- Starve counter:
  - Increments on a tile grant while cpu_valid is high (saturating).
  - Clears on any CPU grant.
  - Clears on a tile grant with cpu_valid low.
- At the grant edge:
  - mem_req <= 1; mem_addr/mem_wdata/mem_wen/mem_size <= winner's fields.
  - owner <= winner; timeout counter <= 0.
- In BUSY:
  - mem_req stays high and the mem_* fields are frozen; requester-side changes are ignored.
  - Timeout counter increments each cycle without mem_ack. Abort when the count reaches ACK_TIMEOUT-1 with no ack.
- Completion edge (mem_ack in BUSY):
  - mem_req <= 0; owner's rdata <= mem_rdata; owner's ready <= 1; err <= 0.
- Abort edge:
  - mem_req <= 0; owner's rdata <= 64'hFFFF_FFFF_FFFF_FFFF; ready <= 1; err <= 1.
  - If mem_ack coincides with the final timeout cycle, the ack wins (normal completion).
- DONE (one cycle):
  - ready/err are high for this cycle only and clear at the DONE→IDLE edge; owner <= 0 at that edge.
  - The requester updates or drops valid at the DONE→IDLE edge. valid is not sampled in DONE.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req high in cycle 1.
  - mem_ack in cycle k → ready in cycle k+1.
  - Two-cycle bubble (DONE, IDLE) between back-to-back transactions.
- Stray mem_ack in IDLE or DONE: ignored.
- The non-owner's ready/err stay 0 throughout. The non-owner's rdata holds its last value.

Decomposition:
- mp64_defs.vh gains:
  - ARB_OWNER_NONE/TILE/CPU (2-bit).
  - ARB_ST_IDLE/BUSY/DONE state encoding.
  - ARB_ERR_RDATA (64'hFFFF_FFFF_FFFF_FFFF).
- One natural sub-module: mp64_arb_timeout, a loadable counter with enable, clear and a terminal-count flag, disabled when ACK_TIMEOUT = 0.
- Grant logic and the starve counter stay inline.

Test Plan:
- CPU alone: read 0x0000_1000, mem_ack after 3 cycles with mem_rdata 0xDEAD_BEEF → cpu_ready one cycle, cpu_rdata 0xDEAD_BEEF, cpu_err 0, mem_req high exactly 3 cycles.
- Tile and CPU both pending at cycle 0, mem_ack always 1 cycle later:
  - Grant order is tile ×4, then CPU, then tile…
  - cpu_ready is observed after exactly 4 tile_ready pulses.
- Field stability: tile changes tile_addr from 0x2000 to 0x3000 while BUSY → mem_addr stays 0x2000 until mem_ack.
- Timeout with ACK_TIMEOUT = 8 and mem_ack never asserted:
  - mem_req high 8 cycles, then cpu_ready = 1, cpu_err = 1, cpu_rdata all-ones.
  - A subsequent request proceeds normally.
- Ack coincides with the final timeout cycle → normal completion, err 0, data = mem_rdata.
- rst asserted mid-BUSY:
  - Next cycle mem_req = 0, owner = 0, no ready pulse.
  - A mem_ack arriving 2 cycles later produces no ready pulse.
